// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package inst_mem_pkg;

    localparam int ADDR_W        = 21;
    localparam int DATA_W        = 32;
    localparam int CNT_W         = 20;
    localparam int MAX_WORDS_DEF = 524288;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_GAP   = 3'd4,
        ST_CHK   = 3'd5,
        ST_FIN   = 3'd6
    } state_e;

endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// Assembles four bytes into a little-endian word; word_valid_o fires combinationally
// with the fourth byte so the caller can act on the same clock edge.
module byte_packer
    import inst_mem_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_valid_o
);

    logic [1:0]  cnt_q;
    logic [23:0] part_q;

    // Earlier bytes shift down so byte0 ends up in [7:0] once the fourth arrives.
    assign word_o       = {byte_i, part_q};
    assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q  <= 2'd0;
            part_q <= 24'd0;
        end else if (byte_valid_i) begin
            cnt_q  <= cnt_q + 2'd1;
            part_q <= {byte_i, part_q[23:8]};
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: byte stream -> header + 32-bit words -> spaced SRAM write pulses.
// Optional trailing XOR checksum byte when INST_LOADER_CHECKSUM_EN is defined.
//
// state    | meaning
// ST_IDLE  | waiting for load_start
// ST_HDR   | collecting 4-byte little-endian word count
// ST_DATA  | collecting 4 bytes of the next word
// ST_WRITE | wr_en high for WR_PULSE cycles
// ST_GAP   | wr_en low for WR_GAP cycles
// ST_CHK   | reading the checksum byte (checksum build only)
// ST_FIN   | one-cycle done pulse
module inst_mem_loader
    import inst_mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                WR_PULSE  = 4,
    parameter int                WR_GAP    = 4,
    parameter int                MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic              load_err,
    output logic [CNT_W-1:0]  words_written
);

    localparam int TMR_MAX = (WR_PULSE > WR_GAP) ? WR_PULSE : WR_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_e              state_q;
    logic [TMR_W-1:0]    timer_q;
    logic [DATA_W-1:0]   n_q;
    logic                rx_ready_q, wr_en_q, busy_q, done_q, load_err_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    words_q;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]          xor_q;
`endif

    logic                pk_valid, pk_clr, word_valid;
    logic [DATA_W-1:0]   word;
    logic [CNT_W-1:0]    words_inc;

    assign pk_valid  = rx_valid && rx_ready_q && (state_q == ST_HDR || state_q == ST_DATA);
    assign pk_clr    = (state_q == ST_IDLE) && load_start;
    assign words_inc = words_q + 20'd1;

    byte_packer u_packer (
        .clk_i        (clk),
        .rst_i        (rst),
        .clr_i        (pk_clr),
        .byte_valid_i (pk_valid),
        .byte_i       (rx_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            n_q        <= '0;
            rx_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            addr_q     <= BASE_ADDR;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
            words_q    <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            xor_q      <= 8'd0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            if (pk_valid) xor_q <= xor_q ^ rx_data;
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        state_q    <= ST_HDR;
                        busy_q     <= 1'b1;
                        rx_ready_q <= 1'b1;
                        load_err_q <= 1'b0;
                        words_q    <= '0;
                        addr_q     <= BASE_ADDR;
`ifdef INST_LOADER_CHECKSUM_EN
                        xor_q      <= 8'd0;
`endif
                    end
                end
                ST_HDR: begin
                    if (word_valid) begin
                        n_q <= word;
                        if (word == '0 || word > 32'(MAX_WORDS)) begin
                            load_err_q <= (word != '0);
                            state_q    <= ST_FIN;
                            rx_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_valid) begin
                        wr_data_q  <= word;
                        wr_en_q    <= 1'b1;
                        rx_ready_q <= 1'b0;
                        timer_q    <= TMR_W'(WR_PULSE - 1);
                        state_q    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (timer_q == '0) begin
                        wr_en_q <= 1'b0;
                        timer_q <= TMR_W'(WR_GAP - 1);
                        state_q <= ST_GAP;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (timer_q == '0) begin
                        words_q <= words_inc;
                        if ({{(DATA_W-CNT_W){1'b0}}, words_inc} == n_q) begin
`ifdef INST_LOADER_CHECKSUM_EN
                            state_q    <= ST_CHK;
                            rx_ready_q <= 1'b1;
`else
                            state_q    <= ST_FIN;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
`endif
                        end else begin
                            // addr only moves here so it holds through the whole pulse+gap
                            addr_q     <= addr_q + 21'd4;
                            rx_ready_q <= 1'b1;
                            state_q    <= ST_DATA;
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
`ifdef INST_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (rx_valid) begin
                        if (rx_data != xor_q) load_err_q <= 1'b1;
                        state_q    <= ST_FIN;
                        rx_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
`endif
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    rx_ready_q <= 1'b0;
                    wr_en_q    <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready      = rx_ready_q;
    assign wr_en         = wr_en_q;
    assign wr_data       = wr_data_q;
    assign addr          = addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign load_err      = load_err_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: two instances (base 0 and base 0x1FFFFC) share stimulus.
module tb_inst_mem_loader;

    localparam int WR_PULSE  = 4;
    localparam int WR_GAP    = 4;
    localparam int MAX_WORDS = 524288;
    localparam int NI        = 2;
    localparam int T_WR      = 1;
    localparam int T_DONE    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_start = 1'b0;
    logic rx_valid = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic rx_ready [NI];
    logic wr_en [NI];
    logic [31:0] wr_data [NI];
    logic [20:0] addr [NI];
    logic busy [NI];
    logic done [NI];
    logic load_err [NI];
    logic [19:0] words_written [NI];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            inst_mem_loader #(
                .BASE_ADDR (g == 0 ? 21'h000000 : 21'h1FFFFC),
                .WR_PULSE  (WR_PULSE),
                .WR_GAP    (WR_GAP),
                .MAX_WORDS (MAX_WORDS)
            ) u_dut (
                .clk           (clk),
                .rst           (rst),
                .load_start    (load_start),
                .rx_data       (rx_data),
                .rx_valid      (rx_valid),
                .rx_ready      (rx_ready[g]),
                .wr_en         (wr_en[g]),
                .wr_data       (wr_data[g]),
                .addr          (addr[g]),
                .busy          (busy[g]),
                .done          (done[g]),
                .load_err      (load_err[g]),
                .words_written (words_written[g])
            );
        end
    endgenerate

    typedef struct { int idx; logic [31:0] data; } wr_exp_t;
    typedef struct { int ww; logic err; } done_exp_t;
    typedef struct { logic [7:0] b; int tag; } byte_t;

    wr_exp_t     exp_wr[$];
    done_exp_t   exp_done[$];
    byte_t       byte_q[$];
    logic [31:0] dir_words[$];
    int wptr [NI];
    int dptr [NI];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_addr(input int k, input int idx);
        int base;
        base = (k == 0) ? 0 : 'h1FFFFC;
        return (base + 4 * idx) % (1 << 21);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit prev_wr [NI];
    bit prev_done [NI];
    int hi [NI];
    int gap [NI];
    logic [31:0] lat_d [NI];
    logic [20:0] lat_a [NI];

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                prev_wr[k] = 1'b0; prev_done[k] = 1'b0; hi[k] = 0; gap[k] = 0;
            end else begin
                if (rx_ready[k]) chk("rdy_needs_busy", 32'(busy[k]), 32'd1);
                if (wr_en[k] && !prev_wr[k]) begin
                    if (wptr[k] < exp_wr.size()) begin
                        chk("wr_addr", 32'(addr[k]), 32'(exp_addr(k, exp_wr[wptr[k]].idx)));
                        chk("wr_data", wr_data[k], exp_wr[wptr[k]].data);
                    end else begin
                        checks++; failures++;
                        $display("FAIL unexpected_write: inst %0d addr 0x%0h none expected", k, addr[k]);
                    end
                    wptr[k]++;
                    lat_a[k] = addr[k]; lat_d[k] = wr_data[k]; hi[k] = 1; gap[k] = 0;
                    chk("rdy_in_write", 32'(rx_ready[k]), 32'd0);
                end else if (wr_en[k]) begin
                    hi[k]++;
                    chk("rdy_in_write", 32'(rx_ready[k]), 32'd0);
                    chk("addr_stable", 32'(addr[k]), 32'(lat_a[k]));
                    chk("data_stable", wr_data[k], lat_d[k]);
                end else if (prev_wr[k]) begin
                    chk("pulse_len", hi[k], WR_PULSE);
                    gap[k] = 1;
                    chk("rdy_in_gap", 32'(rx_ready[k]), 32'd0);
                    chk("addr_stable", 32'(addr[k]), 32'(lat_a[k]));
                end else if (gap[k] > 0) begin
                    gap[k]++;
                    if (gap[k] <= WR_GAP) begin
                        chk("rdy_in_gap", 32'(rx_ready[k]), 32'd0);
                        chk("addr_stable", 32'(addr[k]), 32'(lat_a[k]));
                        chk("data_stable", wr_data[k], lat_d[k]);
                    end else begin
                        chk("gap_len", 32'(rx_ready[k] | done[k]), 32'd1);
                        gap[k] = 0;
                    end
                end
                if (done[k]) begin
                    chk("done_single", 32'(prev_done[k]), 32'd0);
                    if (dptr[k] < exp_done.size()) begin
                        chk("done_words", 32'(words_written[k]), exp_done[dptr[k]].ww);
                        chk("done_err", 32'(load_err[k]), 32'(exp_done[dptr[k]].err));
                        chk("done_busy", 32'(busy[k]), 32'd0);
                    end else begin
                        checks++; failures++;
                        $display("FAIL unexpected_done: inst %0d none expected", k);
                    end
                    dptr[k]++;
                end
                prev_wr[k] = wr_en[k]; prev_done[k] = done[k];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tag_check(input int pend);
        if (pend == T_WR) chk("wr_latency", 32'(wr_en[0]), 32'd1);
        else if (pend == T_DONE) chk("done_latency", 32'(done[0]), 32'd1);
    endtask

    task automatic start_load();
        @(negedge clk);
        rx_valid = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("busy_rise", 32'(busy[0]), 32'd1);
        chk("err_clear", 32'(load_err[0]), 32'd0);
        chk("ww_clear", 32'(words_written[0]), 32'd0);
        chk("hdr_ready", 32'(rx_ready[0]), 32'd1);
    endtask

    task automatic plan_load(input logic [31:0] n, input bit push_done);
        logic [31:0] d;
        bool_ok: begin end
        for (int i = 0; i < 4; i++)
            byte_q.push_back('{n[8*i +: 8], (i == 3 && (n == 0 || n > 32'(MAX_WORDS))) ? T_DONE : 0});
        if (n != 0 && n <= 32'(MAX_WORDS)) begin
            for (int w = 0; w < int'(n); w++) begin
                d = (dir_words.size() > 0) ? dir_words.pop_front() : $urandom;
                exp_wr.push_back('{w, d});
                for (int i = 0; i < 4; i++) byte_q.push_back('{d[8*i +: 8], (i == 3) ? T_WR : 0});
            end
        end
        if (push_done)
            exp_done.push_back('{(n > 32'(MAX_WORDS)) ? 0 : int'(n), (n > 32'(MAX_WORDS))});
    endtask

    task automatic feed(input int count, input bit hold);
        int sent = 0;
        int cyc = 0;
        int pend = 0;
        while (sent < count && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            tag_check(pend);
            pend = 0;
            load_start = !hold && ($urandom_range(0, 15) == 0);
            rx_valid = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
            rx_data = byte_q[0].b;
            if (rx_valid && rx_ready[0]) begin
                pend = byte_q[0].tag;
                void'(byte_q.pop_front());
                sent++;
            end
        end
        if (sent < count) begin
            checks++; failures++;
            $display("FAIL feed_timeout: sent %0d of %0d bytes", sent, count);
        end
        @(negedge clk);
        load_start = 1'b0;
        tag_check(pend);
        if (hold) rx_data = 8'($urandom);
        else rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int cyc = 0;
        while ((dptr[0] < exp_done.size() || dptr[1] < exp_done.size()) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (dptr[0] < exp_done.size() || dptr[1] < exp_done.size()) begin
            checks++; failures++;
            $display("FAIL done_timeout: got %0d/%0d expected %0d", dptr[0], dptr[1], exp_done.size());
        end
    endtask

    task automatic do_load(input logic [31:0] n, input bit hold);
        start_load();
        plan_load(n, 1'b1);
        feed(byte_q.size(), hold);
        wait_done();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] n;
        int r;
        for (int k = 0; k < NI; k++) begin wptr[k] = 0; dptr[k] = 0; end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_rx_ready", 32'(rx_ready[k]), 32'd0);
            chk("rst_wr_en", 32'(wr_en[k]), 32'd0);
            chk("rst_wr_data", wr_data[k], 32'd0);
            chk("rst_addr", 32'(addr[k]), 32'(exp_addr(k, 0)));
            chk("rst_busy", 32'(busy[k]), 32'd0);
            chk("rst_done", 32'(done[k]), 32'd0);
            chk("rst_load_err", 32'(load_err[k]), 32'd0);
            chk("rst_words", 32'(words_written[k]), 32'd0);
        end
        rst = 1'b0;

        // two known words, rx_valid held high (instance 1 wraps its second address)
        dir_words.push_back(32'hDDCCBBAA);
        dir_words.push_back(32'h44332211);
        do_load(32'd2, 1'b1);

        do_load(32'd0, 1'b0);

        do_load(32'(MAX_WORDS + 1), 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("rdy_after_err", 32'(rx_ready[0]), 32'd0);
            chk("err_sticky", 32'(load_err[0]), 32'd1);
        end
        rx_valid = 1'b0;

        // reset during the second cycle of the first write pulse
        start_load();
        plan_load(32'd2, 1'b0);
        feed(8, 1'b0);
        @(negedge clk);
        chk("wr_before_rst", 32'(wr_en[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_wr_en", 32'(wr_en[0]), 32'd0);
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
        chk("rst_mid_wr_en1", 32'(wr_en[1]), 32'd0);
        rst = 1'b0;
        byte_q.delete();
        for (int k = 0; k < NI; k++) wptr[k] = exp_wr.size();
        do_load(32'd1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) n = 32'd0;
            else if (r == 1) n = 32'(MAX_WORDS + 1) + $urandom_range(0, 1000);
            else if (r == 2) n = $urandom | 32'h8000_0000;
            else n = $urandom_range(1, 5);
            do_load(n, 1'($urandom_range(0, 1)));
        end
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
